pixel_shifter: RTL and testbench
================================

Name: pixel_shifter

Overview:
Parametrised, double-buffered pixel serialiser for the CGIA video path. It accepts DATA_W-bit fetched words through a valid/ready handshake into a holding register. It serialises each word MSB-first at 1/2/4/8 bits per pixel, advancing one pixel per dot-clock enable. It reloads from the holding register with no bubble and flags underrun when the fetch path falls behind.

Parameters:
DATA_W, 16, word width; multiple of 8, >= 8.
CNT_W, $clog2(DATA_W)+1, width of the pixels-remaining counter; derived, do not override.

Ports:
dotclk_i  in  1  dot clock; all state updates on its rising edge.
reset_i  in  1  synchronous, active-high reset.
en_i  in  1  pixel advance strobe; one pixel consumed per cycle it is high.
bpp_i  in  2  depth select: 0=1bpp, 1=2bpp, 2=4bpp, 3=8bpp; sampled only at shifter load.
dat_i  in  DATA_W  fetched pixel word.
dat_valid_i  in  1  dat_i valid.
dat_ready_o  out  1  holding register empty; write accepted when dat_valid_i & dat_ready_o.
pixel_o  out  8  current pixel, zero-extended in the low bpp bits.
pixel_valid_o  out  1  pixel_o holds a real pixel.
underrun_o  out  1  one-cycle pulse: last pixel consumed with holding register empty.

Behaviour:
- Reset values: shifter=0, hold empty, cnt=0, bpp_q=0, state=EMPTY, dat_ready_o=1, pixel_o=0, pixel_valid_o=0, underrun_o=0.
- Reset takes priority over every other input. Reset mid-word discards the shifter and hold contents; there is no underrun pulse.
- dat_ready_o = ~hold_full. It is registered, with no combinational path from dat_valid_i or en_i.
- An accepted write sets hold_full the next cycle.
- States:
  - EMPTY: no pixels in shifter. If hold_full: shifter<=hold, bpp_q<=bpp_i, cnt<=DATA_W>>bpp_q_new, hold_full<=0, state->RUN. en_i is ignored in EMPTY.
  - RUN: on en_i: shifter<=shifter<<(1<<bpp_q), cnt<=cnt-1.
    - If en_i and cnt==1 and hold_full: reload as above in the same cycle. No bubble; pixel_valid_o stays 1.
    - If en_i and cnt==1 and !hold_full: state->EMPTY, underrun_o=1 for that cycle (registered, visible next cycle).
    - en_i low: hold all state.
- pixel_o = top (1<<bpp_q) bits of shifter, right-aligned and zero-extended. It is combinational from registers, so a new pixel is visible the cycle after the advancing en_i.
- pixel_valid_o = (state==RUN). In EMPTY, pixel_o is forced to 0.
- Hold write and hold-to-shifter transfer are never simultaneous, because ready is low while hold is full. A write is accepted in the cycle after a transfer.
- A bpp_i change mid-word has no effect until the next load.
- Pixels per word: DATA_W, DATA_W/2, DATA_W/4, DATA_W/8.

Optional Feature:
PIXEL_SHIFTER_LSB_FIRST_EN:
- Defined: the shifter shifts right and pixel_o takes the low (1<<bpp_q) bits, so the first pixel is dat_i[bpp-1:0].
- Undefined: MSB-first as above.
- Counts, handshake and underrun behaviour are identical in both builds.

Test Plan:
- Reset, write 16'h1234 at bpp=2, en_i held high -> pixel_o 1,2,3,4 on consecutive cycles, then underrun_o pulses once and pixel_valid_o=0.
- Write 16'h8001 at bpp=0, en_i high -> 16 pixels: 1, fourteen 0s, 1. Second word 16'hFFFF written during the run -> 16 more 1s follow with pixel_valid_o never dropping and no underrun.
- bpp=3, word 16'hA55A, en_i toggling 1,0,1 -> pixel_o A5, held for the stall cycle, then 5A. dat_ready_o=0 while hold is full.
- Change bpp_i from 3 to 0 mid-word -> the current word finishes as 2 pixels; the next word emits 16 pixels.
- Assert reset_i mid-word -> next cycle pixel_valid_o=0, pixel_o=0, dat_ready_o=1, underrun_o=0.
- LSB_FIRST build, bpp=2, 16'h1234 -> pixel_o 4,3,2,1.

Source files
------------

// File: rtl/pixel_shifter.sv
// -----------------------------------------------------------------------------
// pixel_shifter
//
// Double-buffered pixel serialiser for the CGIA video path. Fetched words are
// written into a one-word holding register through a valid/ready handshake.
// The shifter serialises the word at 1/2/4/8 bits per pixel, one pixel per
// en_i strobe. When the last pixel of a word is consumed, the shifter reloads
// from the holding register in the same cycle, so there is no bubble. If the
// holding register is empty at that point, underrun_o pulses for one cycle.
//
// Build option:
//   PIXEL_SHIFTER_LSB_FIRST_EN  defined   -> pixels leave LSB-first (shift right)
//                               undefined -> pixels leave MSB-first (default)
//
// Parameters:
//   DATA_W  fetched word width (multiple of 8, >= 8)
//   CNT_W   pixels-remaining counter width (derived, do not override)
//
// Ports:
//   dotclk_i       dot clock, all state updates on its rising edge
//   reset_i        synchronous active-high reset
//   en_i           pixel advance strobe (ignored while the shifter is empty)
//   bpp_i          depth select 0..3 = 1/2/4/8 bpp, sampled at shifter load
//   dat_i          fetched pixel word
//   dat_valid_i    dat_i valid
//   dat_ready_o    holding register empty (registered)
//   pixel_o        current pixel, right-aligned and zero-extended
//   pixel_valid_o  pixel_o holds a real pixel
//   underrun_o     one-cycle pulse: word finished with holding register empty
// -----------------------------------------------------------------------------
module pixel_shifter #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              dotclk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic [1:0]        bpp_i,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              dat_valid_i,
  output logic              dat_ready_o,
  output logic [7:0]        pixel_o,
  output logic              pixel_valid_o,
  output logic              underrun_o
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Pixels per word at 1bpp; shifted right by the depth code to get the count.
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_reg;
  logic [DATA_W-1:0] shifter_reg;
  logic [DATA_W-1:0] hold_reg;
  logic              hold_full_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [1:0]        bpp_q_reg;
  logic              underrun_reg;

  // Per-depth views of the shifter: the pixel currently at the output end
  // and the shifter contents after that pixel has been consumed.
  logic [7:0]        pix_cand   [4];
  logic [DATA_W-1:0] shift_cand [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_depth
      localparam int PW = 1 << gi;
`ifdef PIXEL_SHIFTER_LSB_FIRST_EN
      assign pix_cand[gi]   = 8'(shifter_reg[PW-1:0]);
      assign shift_cand[gi] = shifter_reg >> PW;
`else
      assign pix_cand[gi]   = 8'(shifter_reg[DATA_W-1 -: PW]);
      assign shift_cand[gi] = shifter_reg << PW;
`endif
    end
  endgenerate

  always_ff @(posedge dotclk_i) begin
    if (reset_i) begin
      state_reg     <= ST_EMPTY;
      shifter_reg   <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      cnt_reg       <= '0;
      bpp_q_reg     <= 2'd0;
      underrun_reg  <= 1'b0;
    end else begin
      underrun_reg <= 1'b0;

      // Ready is low while hold is full, so a write can never coincide with
      // the hold-to-shifter transfer below (which requires hold full).
      if (dat_valid_i && !hold_full_reg) begin
        hold_reg      <= dat_i;
        hold_full_reg <= 1'b1;
      end

      case (state_reg)
        ST_EMPTY: begin
          if (hold_full_reg) begin
            shifter_reg   <= hold_reg;
            bpp_q_reg     <= bpp_i;
            cnt_reg       <= CNT_FULL >> bpp_i;
            hold_full_reg <= 1'b0;
            state_reg     <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (en_i) begin
            if (cnt_reg == CNT_ONE) begin
              if (hold_full_reg) begin
                // Back-to-back reload: the next word's first pixel follows
                // directly on this word's last one.
                shifter_reg   <= hold_reg;
                bpp_q_reg     <= bpp_i;
                cnt_reg       <= CNT_FULL >> bpp_i;
                hold_full_reg <= 1'b0;
              end else begin
                shifter_reg  <= shift_cand[bpp_q_reg];
                cnt_reg      <= '0;
                state_reg    <= ST_EMPTY;
                underrun_reg <= 1'b1;
              end
            end else begin
              shifter_reg <= shift_cand[bpp_q_reg];
              cnt_reg     <= cnt_reg - CNT_ONE;
            end
          end
        end

        default: state_reg <= ST_EMPTY;
      endcase
    end
  end

  assign dat_ready_o   = ~hold_full_reg;
  assign pixel_valid_o = (state_reg == ST_RUN);
  assign pixel_o       = (state_reg == ST_RUN) ? pix_cand[bpp_q_reg] : 8'd0;
  assign underrun_o    = underrun_reg;

endmodule

// File: tb/tb_pixel_shifter.sv
// -----------------------------------------------------------------------------
// tb_pixel_shifter
//
// Self-checking bench for pixel_shifter. A reference model keeps the pending
// pixels of the current word as a queue and the holding register as a single
// slot; every cycle all four outputs are compared against it. Directed steps
// cover the documented scenarios, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_pixel_shifter;

  localparam int DATA_W = 16;

  logic              dotclk_i;
  logic              reset_i;
  logic              en_i;
  logic [1:0]        bpp_i;
  logic [DATA_W-1:0] dat_i;
  logic              dat_valid_i;
  logic              dat_ready_o;
  logic [7:0]        pixel_o;
  logic              pixel_valid_o;
  logic              underrun_o;

  pixel_shifter #(.DATA_W(DATA_W)) dut (
    .dotclk_i      (dotclk_i),
    .reset_i       (reset_i),
    .en_i          (en_i),
    .bpp_i         (bpp_i),
    .dat_i         (dat_i),
    .dat_valid_i   (dat_valid_i),
    .dat_ready_o   (dat_ready_o),
    .pixel_o       (pixel_o),
    .pixel_valid_o (pixel_valid_o),
    .underrun_o    (underrun_o)
  );

  initial begin
    dotclk_i = 1'b0;
    forever #5 dotclk_i = ~dotclk_i;
  end

  // Reference model state
  logic [7:0]        m_pix [$];
  logic [DATA_W-1:0] m_hold;
  bit                m_hold_v;
  bit                m_under;

  int checks;
  int errors;

  // Split a word into its pixel sequence at the given depth.
  function automatic void load_word(input logic [DATA_W-1:0] w, input logic [1:0] b);
    int pw;
    int n;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] tmp;
    pw   = 1 << b;
    n    = DATA_W / pw;
    mask = DATA_W'((1 << pw) - 1);
    m_pix.delete();
    for (int k = 0; k < n; k++) begin
`ifdef PIXEL_SHIFTER_LSB_FIRST_EN
      tmp = w >> (k * pw);
`else
      tmp = w >> (DATA_W - (k + 1) * pw);
`endif
      m_pix.push_back(8'(tmp & mask));
    end
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  function automatic void model_update();
    bit accept;
    bit nu;
    logic [7:0] dummy;
    if (reset_i) begin
      m_pix.delete();
      m_hold_v = 1'b0;
      m_hold   = '0;
      m_under  = 1'b0;
      return;
    end
    accept = dat_valid_i && !m_hold_v;
    nu     = 1'b0;
    if (m_pix.size() == 0) begin
      if (m_hold_v) begin
        load_word(m_hold, bpp_i);
        m_hold_v = 1'b0;
      end
    end else if (en_i) begin
      dummy = m_pix.pop_front();
      if (m_pix.size() == 0) begin
        if (m_hold_v) begin
          load_word(m_hold, bpp_i);
          m_hold_v = 1'b0;
        end else begin
          nu = 1'b1;
        end
      end
    end
    if (accept) begin
      m_hold   = dat_i;
      m_hold_v = 1'b1;
    end
    m_under = nu;
  endfunction

  task automatic check(input string tag);
    logic [7:0] exp_pix;
    logic       exp_valid;
    logic       exp_ready;
    logic       exp_under;
    exp_valid = (m_pix.size() != 0);
    exp_pix   = exp_valid ? m_pix[0] : 8'd0;
    exp_ready = !m_hold_v;
    exp_under = m_under;

    checks++;
    assert (pixel_o === exp_pix) else begin
      errors++;
      $error("FAIL %s pixel_o observed %0h expected %0h", tag, pixel_o, exp_pix);
    end
    checks++;
    assert (pixel_valid_o === exp_valid) else begin
      errors++;
      $error("FAIL %s pixel_valid_o observed %0b expected %0b", tag, pixel_valid_o, exp_valid);
    end
    checks++;
    assert (dat_ready_o === exp_ready) else begin
      errors++;
      $error("FAIL %s dat_ready_o observed %0b expected %0b", tag, dat_ready_o, exp_ready);
    end
    checks++;
    assert (underrun_o === exp_under) else begin
      errors++;
      $error("FAIL %s underrun_o observed %0b expected %0b", tag, underrun_o, exp_under);
    end
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic step(input string tag);
    @(posedge dotclk_i);
    model_update();
    #1;
    check(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    m_hold      = '0;
    m_hold_v    = 1'b0;
    m_under     = 1'b0;
    reset_i     = 1'b1;
    en_i        = 1'b0;
    bpp_i       = 2'd0;
    dat_i       = '0;
    dat_valid_i = 1'b0;

    // Reset state
    steps("reset", 2);
    reset_i = 1'b0;
    step("idle");

    // 4bpp word with en held high, then underrun
    dat_i = 16'h1234; bpp_i = 2'd2; dat_valid_i = 1'b1;
    step("w1234_accept");
    dat_valid_i = 1'b0; en_i = 1'b1;
    steps("w1234_run", 8);

    // 1bpp word followed by a second word written during the run
    en_i = 1'b0; bpp_i = 2'd0; dat_i = 16'h8001; dat_valid_i = 1'b1;
    step("w8001_accept");
    dat_i = 16'hFFFF; en_i = 1'b1;
    steps("w8001_ffff_run", 4);
    dat_valid_i = 1'b0;
    steps("w8001_ffff_run", 34);

    // 8bpp with a stall cycle between pixels
    en_i = 1'b0; bpp_i = 2'd3; dat_i = 16'hA55A; dat_valid_i = 1'b1;
    step("wa55a_accept");
    dat_valid_i = 1'b0;
    step("wa55a_load");
    en_i = 1'b1; step("wa55a_en1");
    en_i = 1'b0; step("wa55a_stall");
    en_i = 1'b1; steps("wa55a_en2", 3);

    // bpp change mid-word only affects the next load
    en_i = 1'b0; bpp_i = 2'd3; dat_i = 16'hC3C3; dat_valid_i = 1'b1;
    step("bppchg_accept1");
    dat_i = 16'h0F0F;
    step("bppchg_load1");
    bpp_i = 2'd0; en_i = 1'b1;
    steps("bppchg_run", 3);
    dat_valid_i = 1'b0;
    steps("bppchg_run", 18);

    // Reset mid-word
    en_i = 1'b0; bpp_i = 2'd1; dat_i = 16'h9E37; dat_valid_i = 1'b1;
    step("rst_accept");
    dat_i = 16'h1111;
    step("rst_load");
    en_i = 1'b1;
    steps("rst_run", 2);
    reset_i = 1'b1;
    step("rst_mid");
    reset_i = 1'b0; dat_valid_i = 1'b0; en_i = 1'b0;
    steps("rst_after", 2);

    // Randomized traffic in phases of varying fetch pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 300; i++) begin
        en_i        = ($urandom_range(0, 3) != 0);
        dat_valid_i = ($urandom_range(0, 7) < (2 + 2 * ph));
        bpp_i       = 2'($urandom_range(0, 3));
        dat_i       = DATA_W'($urandom);
        reset_i     = ($urandom_range(0, 249) == 0);
        step("random");
      end
    end
    reset_i = 1'b0; en_i = 1'b0; dat_valid_i = 1'b0;
    steps("drain", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
